// File: rtl/vend_credit_fsm.sv
// vend_credit_fsm: registered vending controller owning credit and state for one channel
// Optional build macro VEND_COIN_REJECT_EN: coins arriving while busy pulse coin_reject.
module vend_credit_fsm #(
    parameter int CREDIT_W = 5,
    parameter int PRICE    = 6,
    parameter int V1       = 1,
    parameter int V2       = 2,
    parameter int V3       = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                dispense_ack,
    output logic                dispense,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject
);
    localparam int VMAX = (V1 > V2) ? ((V1 > V3) ? V1 : V3) : ((V2 > V3) ? V2 : V3);

    if (PRICE < 1 || PRICE > (2 ** CREDIT_W) - 1 || PRICE - 1 + VMAX >= 2 ** CREDIT_W ||
        V1 < 1 || V2 < 1 || V3 < 1) begin : g_bad_params
        $error("vend_credit_fsm: illegal PRICE/V*/CREDIT_W combination");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, coin_val, sum;
    logic                accepted, dispense_q, change_q, busy_q, reject_q, reject_d;

    assign accepted = coin_valid && coin != 2'b00;
    assign coin_val = coin == 2'b01 ? CREDIT_W'(V1) : coin == 2'b10 ? CREDIT_W'(V2) : CREDIT_W'(V3);
    assign sum      = credit_q + coin_val;

    // next state and credit; a coin is added before any same-edge cancel is honoured
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (accepted) begin
                    if (sum >= CREDIT_W'(PRICE)) begin
                        state_d  = VEND;
                        credit_d = sum - CREDIT_W'(PRICE);
                    end else begin
                        state_d  = (cancel && state_q == ACCUM) ? CHANGE : ACCUM;
                        credit_d = sum;
                    end
                end else if (cancel && state_q == ACCUM) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                if (dispense_ack) state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                credit_d = credit_q - CREDIT_W'(1);
                if (credit_q == CREDIT_W'(1)) state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
`ifdef VEND_COIN_REJECT_EN
        reject_d = accepted && (state_q == VEND || state_q == CHANGE);
`endif
    end

    // state, credit and Moore outputs all registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= state_d == VEND;
            change_q   <= state_d == CHANGE;
            busy_q     <= state_d == VEND || state_d == CHANGE;
            reject_q   <= reject_d;
        end
    end

    assign dispense     = dispense_q;
    assign change_pulse = change_q;
    assign busy         = busy_q;
    assign credit       = credit_q;
    assign coin_reject  = reject_q;
endmodule
